// File: rtl/pla_eval_sched.sv
// pla_eval_sched: schedules two requesters onto one shared combinational PLA.
// A granted vector is registered onto eval_in, held for SETTLE_CYCLES edges,
// and the PLA output is then captured and presented on the response port.
// Optional feature macro: PLA_EVAL_TOGGLE_CNT_EN adds the toggle_cnt output,
// a saturating count of bits that change between successive captured results.
//
// state  | meaning
// IDLE   | waiting for a request, arbitrating round-robin
// SETTLE | eval_in driven, counting down until the PLA output is stable
// RESP   | captured result presented until the consumer accepts it
module pla_eval_sched #(
   parameter int W             = 14,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_vec,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_vec,
   output logic         req1_ready,
   output logic [W-1:0] eval_in,
   input  logic [W-1:0] eval_out,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   input  logic         rsp_ready,
   output logic         busy
`ifdef PLA_EVAL_TOGGLE_CNT_EN
   ,
   output logic [15:0]  toggle_cnt
`endif
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [W-1:0] eval_in_q, eval_in_d;
   logic [W-1:0] rsp_data_q, rsp_data_d;
   logic         rsp_id_q, rsp_id_d;
   logic         last_q, last_d;
   logic         grant;
   logic         accept;

   // Round-robin grant: on contention the requester not served last wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
      req0_ready = (state_q == ST_IDLE) && !rst && req0_valid && !grant;
      req1_ready = (state_q == ST_IDLE) && !rst && req1_valid && grant;
      accept     = req0_ready || req1_ready;
   end

   // Next-state and datapath; the settle timer is a down-counter whose
   // terminal count (1) marks the capture edge.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      eval_in_d  = eval_in_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      last_d     = last_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               eval_in_d = grant ? req1_vec : req0_vec;
               rsp_id_d  = grant;
               last_d    = grant;
               cnt_d     = 4'(SETTLE_CYCLES);
               state_d   = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               rsp_data_d = eval_out;
               state_d    = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; last-served resets to 1 so
   // requester 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         eval_in_q  <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= 1'b0;
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         eval_in_q  <= eval_in_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         last_q     <= last_d;
      end
   end

`ifdef PLA_EVAL_TOGGLE_CNT_EN
   logic [15:0] toggle_q, toggle_d;
   logic [15:0] pop;
   logic [16:0] sum;
   logic [W-1:0] diff;

   // Saturating accumulate of bit flips between the old and new captured result.
   always_comb begin
      diff = eval_out ^ rsp_data_q;
      pop  = '0;
      for (int i = 0; i < W; i++) begin
         pop = pop + 16'(diff[i]);
      end
      sum      = {1'b0, toggle_q} + {1'b0, pop};
      toggle_d = toggle_q;
      if (state_q == ST_SETTLE && cnt_q == 4'd1) begin
         toggle_d = sum[16] ? 16'hFFFF : sum[15:0];
      end
   end

   // Toggle counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         toggle_q <= '0;
      end else begin
         toggle_q <= toggle_d;
      end
   end

   assign toggle_cnt = toggle_q;
`endif

   assign eval_in   = eval_in_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_valid = (state_q == ST_RESP);
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pla_eval_sched.sv
// Bench for pla_eval_sched: two instances (settle 1 and settle 4) checked each
// cycle against a transaction-level model, plus directed literal expectations.
module tb_pla_eval_sched;

   logic        clk;
   logic        rst;
   logic        r0v[2], r1v[2], rspr[2];
   logic [13:0] r0vec[2], r1vec[2], eo[2];
   logic        r0r[2], r1r[2], rv[2], rid[2], bsy[2];
   logic [13:0] ei[2], rd[2];
   logic [15:0] tc[2];

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   bit a0[2], a1[2];

   // behavioural model state
   bit          m_idle[2] = '{1'b1, 1'b1};
   bit          m_resp[2] = '{1'b0, 1'b0};
   int          m_left[2] = '{0, 0};
   logic [13:0] m_ein[2]  = '{14'h0, 14'h0};
   logic [13:0] m_data[2] = '{14'h0, 14'h0};
   bit          m_id[2]   = '{1'b0, 1'b0};
   bit          m_last[2] = '{1'b1, 1'b1};
   int          m_tog[2]  = '{0, 0};

   pla_eval_sched #(.W(14), .SETTLE_CYCLES(1)) u_dut_s1 (
      .clk(clk), .rst(rst),
      .req0_valid(r0v[0]), .req0_vec(r0vec[0]), .req0_ready(r0r[0]),
      .req1_valid(r1v[0]), .req1_vec(r1vec[0]), .req1_ready(r1r[0]),
      .eval_in(ei[0]), .eval_out(eo[0]),
      .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_data(rd[0]), .rsp_ready(rspr[0]),
      .busy(bsy[0])
`ifdef PLA_EVAL_TOGGLE_CNT_EN
      , .toggle_cnt(tc[0])
`endif
   );

   pla_eval_sched #(.W(14), .SETTLE_CYCLES(4)) u_dut_s4 (
      .clk(clk), .rst(rst),
      .req0_valid(r0v[1]), .req0_vec(r0vec[1]), .req0_ready(r0r[1]),
      .req1_valid(r1v[1]), .req1_vec(r1vec[1]), .req1_ready(r1r[1]),
      .eval_in(ei[1]), .eval_out(eo[1]),
      .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_data(rd[1]), .rsp_ready(rspr[1]),
      .busy(bsy[1])
`ifdef PLA_EVAL_TOGGLE_CNT_EN
      , .toggle_cnt(tc[1])
`endif
   );

`ifndef PLA_EVAL_TOGGLE_CNT_EN
   assign tc[0] = 16'h0;
   assign tc[1] = 16'h0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int s_of(int i);
      return (i == 0) ? 1 : 4;
   endfunction

   // index of the requester that should win given the valids and last-served
   function automatic bit gnt(bit v0, bit v1, bit last);
      if (v0 && v1) return !last;
      return v1 && !v0;
   endfunction

   // Transaction-level model: one request in flight, settles for s_of(i) edges,
   // then waits for the consumer.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_idle[i] <= 1'b1; m_resp[i] <= 1'b0; m_left[i] <= 0;
            m_ein[i] <= '0; m_data[i] <= '0; m_id[i] <= 1'b0;
            m_last[i] <= 1'b1; m_tog[i] <= 0;
         end else if (m_idle[i]) begin
            if (r0v[i] || r1v[i]) begin
               m_ein[i]  <= gnt(r0v[i], r1v[i], m_last[i]) ? r1vec[i] : r0vec[i];
               m_id[i]   <= gnt(r0v[i], r1v[i], m_last[i]);
               m_last[i] <= gnt(r0v[i], r1v[i], m_last[i]);
               m_left[i] <= s_of(i);
               m_idle[i] <= 1'b0;
            end
         end else if (m_left[i] > 0) begin
            m_left[i] <= m_left[i] - 1;
            if (m_left[i] == 1) begin
               m_data[i] <= eo[i];
               m_resp[i] <= 1'b1;
`ifdef PLA_EVAL_TOGGLE_CNT_EN
               m_tog[i] <= (m_tog[i] + $countones(eo[i] ^ m_data[i]) > 65535) ?
                           65535 : m_tog[i] + $countones(eo[i] ^ m_data[i]);
`endif
            end
         end else if (rspr[i]) begin
            m_resp[i] <= 1'b0;
            m_idle[i] <= 1'b1;
         end
      end
   end

   task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[inst%0d] t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
      end
   endtask

   task automatic compare_cycle();
      for (int i = 0; i < 2; i++) begin
         bit g;
         g = gnt(r0v[i], r1v[i], m_last[i]);
         chk("req0_ready", i, 32'(r0r[i]), 32'(m_idle[i] && !rst && r0v[i] && !g));
         chk("req1_ready", i, 32'(r1r[i]), 32'(m_idle[i] && !rst && r1v[i] && g));
         chk("eval_in", i, 32'(ei[i]), 32'(m_ein[i]));
         chk("rsp_valid", i, 32'(rv[i]), 32'(m_resp[i]));
         chk("rsp_data", i, 32'(rd[i]), 32'(m_data[i]));
         chk("rsp_id", i, 32'(rid[i]), 32'(m_id[i]));
         chk("busy", i, 32'(bsy[i]), 32'(!m_idle[i]));
`ifdef PLA_EVAL_TOGGLE_CNT_EN
         chk("toggle_cnt", i, 32'(tc[i]), 32'(m_tog[i]));
`endif
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
      cycle++;
      if (cycle > 80000) begin
         $display("FAIL cycle_budget: got %0d cycles expected at most 80000", cycle);
         $fatal(1, "cycle budget exhausted");
      end
      compare_cycle();
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         r0v[i] = 1'b0; r1v[i] = 1'b0; rspr[i] = 1'b0;
         r0vec[i] = '0; r1vec[i] = '0; eo[i] = '0;
      end
      r0v[0] = 1'b1; r0vec[0] = 14'h0001;

      // reset: ready low even with valid high, outputs at reset values
      to_neg();
      chk("ready_during_rst", 0, 32'(r0r[0]), 32'd0);
      to_drive();
      to_neg();
      chk("rst_eval_in", 0, 32'(ei[0]), 32'd0);
      chk("rst_busy", 0, 32'(bsy[0]), 32'd0);
      to_drive();
      rst = 1'b0;
      eo[0] = 14'h2AAA;

      // single request, settle 1
      to_neg();
      chk("s1_ready_hi", 0, 32'(r0r[0]), 32'd1);
      to_drive();
      r0v[0] = 1'b0;
      to_neg();
      chk("s1_ready_lo", 0, 32'(r0r[0]), 32'd0);
      chk("s1_eval_in", 0, 32'(ei[0]), 32'h0001);
      chk("s1_no_rsp_yet", 0, 32'(rv[0]), 32'd0);
      to_drive();
      to_neg();
      chk("s1_rsp_valid", 0, 32'(rv[0]), 32'd1);
      chk("s1_rsp_data", 0, 32'(rd[0]), 32'h2AAA);
      chk("s1_rsp_id", 0, 32'(rid[0]), 32'd0);
      to_drive();
      rspr[0] = 1'b1;
      to_neg();
      to_drive();
      to_neg();
      chk("s1_back_idle", 0, 32'(bsy[0]), 32'd0);

      // settle 4, PLA output changes two cycles after acceptance
      to_drive();
      eo[1] = 14'h0000; r0v[1] = 1'b1; r0vec[1] = 14'h0A5A;
      to_neg();
      chk("s4_ready_hi", 1, 32'(r0r[1]), 32'd1);
      to_drive();
      r0v[1] = 1'b0;
      to_neg();
      to_drive();
      to_neg();
      to_drive();
      eo[1] = 14'h1234;
      to_neg();
      chk("s4_rsp_early2", 1, 32'(rv[1]), 32'd0);
      to_drive();
      to_neg();
      chk("s4_rsp_early3", 1, 32'(rv[1]), 32'd0);
      to_drive();
      to_neg();
      chk("s4_rsp_valid", 1, 32'(rv[1]), 32'd1);
      chk("s4_rsp_data", 1, 32'(rd[1]), 32'h1234);

      // consumer stalls 10 cycles; pending req1 stays unready
      to_drive();
      r1v[1] = 1'b1; r1vec[1] = 14'h0555; eo[1] = 14'h3333;
      for (int c = 0; c < 10; c++) begin
         to_neg();
         chk("stall_rsp_valid", 1, 32'(rv[1]), 32'd1);
         chk("stall_rsp_data", 1, 32'(rd[1]), 32'h1234);
         chk("stall_req1_ready", 1, 32'(r1r[1]), 32'd0);
         to_drive();
         r1vec[1] = (c == 9) ? 14'h0555 : 14'($urandom);
      end
      rspr[1] = 1'b1;
      to_neg();
      chk("exit_req1_ready", 1, 32'(r1r[1]), 32'd0);
      to_drive();
      rspr[1] = 1'b0;
      to_neg();
      chk("after_idle_req1_ready", 1, 32'(r1r[1]), 32'd1);
      to_drive();
      r1v[1] = 1'b0;
      to_neg();
      chk("req1_eval_in", 1, 32'(ei[1]), 32'h0555);
      chk("req1_rsp_id", 1, 32'(rid[1]), 32'd1);

      // reset pulse during settle aborts the request
      to_drive();
      rst = 1'b1;
      to_neg();
      to_drive();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         to_neg();
         chk("abort_rsp_valid", 1, 32'(rv[1]), 32'd0);
         chk("abort_rsp_data", 1, 32'(rd[1]), 32'd0);
         chk("abort_eval_in", 1, 32'(ei[1]), 32'd0);
         to_drive();
      end

      // contention with consumer always ready: ids alternate 0,1,0,1
      r0v[0] = 1'b1; r1v[0] = 1'b1; rspr[0] = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         r0vec[0] = 14'($urandom); r1vec[0] = 14'($urandom); eo[0] = 14'($urandom);
         to_neg();
         if (rv[0]) begin
            chk("alt_rsp_id", 0, 32'(rid[0]), 32'(n % 2));
            n++;
         end
         to_drive();
      end
      chk("alt_count", 0, 32'(n), 32'd4);
      r0v[0] = 1'b0; r1v[0] = 1'b0;

`ifdef PLA_EVAL_TOGGLE_CNT_EN
      rst = 1'b1;
      to_neg();
      to_drive();
      rst = 1'b0; rspr[0] = 1'b1;
      eo[0] = 14'h3FFF; r0v[0] = 1'b1;
      to_neg();
      to_drive();
      r0v[0] = 1'b0;
      to_neg();
      to_drive();
      to_neg();
      chk("tog_first", 0, 32'(tc[0]), 32'd14);
      to_drive();
      eo[0] = 14'h0000; r0v[0] = 1'b1;
      to_neg();
      to_drive();
      r0v[0] = 1'b0;
      to_neg();
      to_drive();
      to_neg();
      chk("tog_second", 0, 32'(tc[0]), 32'd28);
      to_drive();
      r0v[0] = 1'b1;
      for (int c = 0; c < 15500; c++) begin
         to_neg();
         to_drive();
         eo[0] = rd[0] ^ 14'h3FFF;
      end
      to_neg();
      chk("tog_saturated", 0, 32'(tc[0]), 32'hFFFF);
      to_drive();
      r0v[0] = 1'b0;
`endif

      // randomized traffic on both instances
      for (int c = 0; c < 3000; c++) begin
         to_neg();
         for (int i = 0; i < 2; i++) begin
            a0[i] = r0v[i] && r0r[i];
            a1[i] = r1v[i] && r1r[i];
         end
         to_drive();
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < 2; i++) begin
            if (a0[i] || !r0v[i]) r0v[i] = ($urandom_range(0, 2) != 0);
            if (a1[i] || !r1v[i]) r1v[i] = ($urandom_range(0, 2) != 0);
            r0vec[i] = 14'($urandom);
            r1vec[i] = 14'($urandom);
            rspr[i]  = ($urandom_range(0, 3) != 0);
            eo[i]    = 14'($urandom);
         end
      end
      to_neg();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pla_eval_sched.md
PLA_EVAL_SCHED -- requirements
Module: pla_eval_sched

Interface
REQ-001 Parameter: W, default 14, width of the input and output vectors of the shared PLA evaluation block.
REQ-002 Parameter: SETTLE_CYCLES, default 1, legal range 1..15; number of cycles `eval_in` is held stable before `eval_out` is captured.
REQ-003 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port: rst, input, 1, reset; synchronous, active-high.
REQ-005 Port: req0_valid, input, 1, requester 0 has a vector to evaluate.
REQ-006 Port: req0_vec, input, W, requester 0 input vector.
REQ-007 Port: req0_ready, output, 1, requester 0 vector accepted this cycle.
REQ-008 Port: req1_valid, input, 1, requester 1 has a vector to evaluate.
REQ-009 Port: req1_vec, input, W, requester 1 input vector.
REQ-010 Port: req1_ready, output, 1, requester 1 vector accepted this cycle.
REQ-011 Port: eval_in, output, W, registered drive to the shared combinational PLA inputs.
REQ-012 Port: eval_out, input, W, shared PLA outputs.
REQ-013 Port: rsp_valid, output, 1, result available.
REQ-014 Port: rsp_id, output, 1, requester index that owns the result.
REQ-015 Port: rsp_data, output, W, captured PLA result.
REQ-016 Port: rsp_ready, input, 1, consumer accepts the result.
REQ-017 Port: busy, output, 1, high whenever the state is not IDLE.
REQ-018 Port: toggle_cnt, output, 16, output-activity count; present only under the configuration macro.

Function
REQ-019 The FSM SHALL have three states: IDLE, SETTLE and RESP.
REQ-020 In IDLE, `reqN_ready` SHALL be high combinationally only for the granted requester N with `reqN_valid` high; at most one ready is high per cycle.
REQ-021 Arbitration SHALL be round-robin: when both requesters are valid, the grant goes to the requester not served last; when only one is valid, that requester is granted.
REQ-022 On an accepting edge (valid & ready), the block SHALL:
- load `eval_in` with the vector;
- load `rsp_id` with N;
- update last-served to N;
- load the settle counter with SETTLE_CYCLES;
- go to SETTLE.
REQ-023 In SETTLE, the counter SHALL decrement at each edge; at the edge where the counter equals 1, `eval_out` is registered into `rsp_data` and the state becomes RESP.
REQ-024 Latency: `rsp_valid` SHALL rise immediately after the SETTLE_CYCLES-th rising edge following the accepting edge.
REQ-025 In RESP, `rsp_valid` SHALL be high, and `rsp_data` and `rsp_id` stable; on `rsp_valid & rsp_ready` the state becomes IDLE.
REQ-026 No request SHALL be accepted in the RESP-to-IDLE transition cycle; the earliest next acceptance is the following cycle.
REQ-027 `eval_in` SHALL hold its last vector in IDLE and RESP; it changes only on an accepting edge (power: no spurious input toggling).
REQ-028 Requests arriving in SETTLE or RESP SHALL see ready low and must hold valid until accepted.
REQ-029 Changing `reqN_vec` while `reqN_ready` is low SHALL have no effect.

Reset
REQ-030 While `rst` is high at a rising edge, the block SHALL set:
- state to IDLE;
- `eval_in`, `rsp_data` and `rsp_id` to 0;
- `rsp_valid` and `busy` to 0;
- settle counter to 0;
- last-served to 1, so requester 0 wins the first contention;
- `toggle_cnt` to 0 when configured.
REQ-031 Reset asserted in SETTLE or RESP SHALL abort the operation; the in-flight result is discarded and never presented.
REQ-032 `reqN_ready` SHALL be low during any cycle in which `rst` is high.

Configuration
REQ-033 Macro: PLA_EVAL_TOGGLE_CNT_EN.
REQ-034 When PLA_EVAL_TOGGLE_CNT_EN is defined, at each capture edge `toggle_cnt` SHALL increase by popcount(new `eval_out` XOR current `rsp_data`), saturating at 16'hFFFF.
REQ-035 When PLA_EVAL_TOGGLE_CNT_EN is undefined, the `toggle_cnt` port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Scenario: reset, then req0_valid=1 with vec=14'h0001 and SETTLE_CYCLES=1, with eval_out tied to 14'h2AAA -> req0_ready is high for 1 cycle; rsp_valid rises after the next edge with rsp_data=14'h2AAA and rsp_id=0.
REQ-037 Scenario: req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence is 0,1,0,1.
REQ-038 Scenario: SETTLE_CYCLES=4, with eval_out changing from 14'h0000 to 14'h1234 two cycles after acceptance -> rsp_data=14'h1234, captured 4 edges after acceptance.
REQ-039 Scenario: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stay stable; req1_valid=1 sees req1_ready=0 throughout; after rsp_ready=1, req1 is accepted the cycle after the IDLE return.
REQ-040 Scenario: rst pulsed for one cycle during SETTLE -> no rsp_valid ever appears for that request; all outputs read reset values.
REQ-041 Scenario, with PLA_EVAL_TOGGLE_CNT_EN: captures of 14'h3FFF then 14'h0000 -> toggle_cnt reads 14 after the first capture and 28 after the second; preloaded near saturation, it holds at 16'hFFFF.
